// File: rtl/fp_normround64.sv
// fp_normround64: four-stage normalize/round/pack of an FP64X adder result into an IEEE double.
// Define FP_NORMROUND_FLAGS_EN to build the inexact/overflow/underflow flag pipeline.
module fp_normround64 #(
    parameter int FMSB = 51,
    parameter int EMSB = 10,
    parameter int FX   = 105
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [2:0]           rm,
    input  logic                 i_valid,
    input  logic [FX+EMSB+2:0]   i,
    output logic [FMSB+EMSB+2:0] o,
    output logic                 o_valid,
    output logic                 inexact,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int HB   = FX - 1;
    localparam int FLSB = HB - FMSB - 1;
    localparam int GB   = FLSB - 1;
    localparam int RB   = FLSB - 2;
    localparam int LZW  = $clog2(FX + 1);
    localparam int EW   = EMSB + 1;
    localparam int PW   = EMSB + FMSB + 2;

    logic             w_sign;
    logic [EMSB:0]    w_exp;
    logic [FX:0]      w_sig;
    logic [2:0]       w_rm;
    logic [LZW-1:0]   w_lz;

    assign w_sign = i[FX+EMSB+2];
    assign w_exp  = i[FX+EMSB+1:FX+1];
    assign w_sig  = i[FX:0];
    assign w_rm   = (rm > 3'd4) ? 3'd0 : rm;

    // Highest set bit wins; an all-zero significand counts as FX leading zeros.
    always_comb begin
        w_lz = LZW'(FX);
        for (int k = 0; k <= HB; k++) begin
            if (w_sig[k]) w_lz = LZW'(HB - k);
        end
    end

    logic             r_v1, r_sign1, r_special1;
    logic [2:0]       r_rm1;
    logic [EMSB:0]    r_eEff1;
    logic [LZW-1:0]   r_lz1;
    logic [FX:0]      r_sig1;

    logic [EMSB:0]    w_lim, w_lzExt, w_shamt, w_exp2;
    logic [HB:0]      w_shl;
    logic [HB-1:0]    w_sig2;
    logic             w_xs2;

    assign w_lim   = r_eEff1 - EW'(1);
    assign w_lzExt = EW'(r_lz1);
    assign w_shamt = (w_lzExt < w_lim) ? w_lzExt : w_lim;
    assign w_shl   = r_sig1[HB:0] << w_shamt;

    // Hidden bit is dropped here; a shift limited by the exponent leaves a denormal.
    always_comb begin
        w_exp2 = r_eEff1 - w_shamt;
        w_sig2 = w_shl[HB-1:0];
        w_xs2  = 1'b0;
        if (r_special1) begin
            w_exp2            = '1;
            w_sig2            = '0;
            w_sig2[HB-1:FLSB] = r_sig1[HB-1:FLSB];
        end else if (r_sig1[FX]) begin
            w_exp2 = r_eEff1 + EW'(1);
            w_sig2 = r_sig1[HB:1];
            w_xs2  = r_sig1[0];
        end else if (!w_shl[HB]) begin
            w_exp2 = '0;
        end
    end

    logic             r_v2, r_sign2, r_special2, r_xs2;
    logic [2:0]       r_rm2;
    logic [EMSB:0]    r_exp2;
    logic [HB-1:0]    r_sig2;

    logic             w_lsb, w_g, w_r, w_s, w_grs, w_inc;

    assign w_lsb = r_sig2[FLSB];
    assign w_g   = r_sig2[GB];
    assign w_r   = r_sig2[RB];
    assign w_s   = (|r_sig2[RB-1:0]) | r_xs2;
    assign w_grs = w_g | w_r | w_s;

    always_comb begin
        w_inc = w_g & (w_r | w_s | w_lsb);
        case (r_rm2)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = ~r_sign2 & w_grs;
            3'd3:    w_inc = r_sign2 & w_grs;
            3'd4:    w_inc = w_g;
            default: w_inc = w_g & (w_r | w_s | w_lsb);
        endcase
    end

    logic             r_v3, r_sign3, r_special3, r_inc3;
    logic [2:0]       r_rm3;
    logic [EMSB:0]    r_exp3;
    logic [FMSB:0]    r_frac3;

    logic [PW-1:0]    w_sum;
    logic             w_ovf, w_toInf;
    logic [PW:0]      w_res;

    // Rounding into the packed {exp, frac} lets fraction carries bump the exponent.
    assign w_sum   = {r_exp3, r_frac3} + PW'(r_inc3);
    assign w_ovf   = !r_special3 && (&w_sum[PW-1:FMSB+1]);
    assign w_toInf = (r_rm3 == 3'd0) || (r_rm3 == 3'd4) ||
                     ((r_rm3 == 3'd2) && !r_sign3) || ((r_rm3 == 3'd3) && r_sign3);

    always_comb begin
        w_res = {r_sign3, w_sum};
        if (w_ovf) begin
            if (w_toInf) w_res = {r_sign3, {EW{1'b1}}, {(FMSB+1){1'b0}}};
            else         w_res = {r_sign3, {EMSB{1'b1}}, 1'b0, {(FMSB+1){1'b1}}};
        end
    end

    logic             r_v4;
    logic [PW:0]      r_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0; r_sign1 <= 1'b0; r_special1 <= 1'b0; r_rm1 <= '0;
            r_eEff1 <= '0; r_lz1 <= '0; r_sig1 <= '0;
            r_v2 <= 1'b0; r_sign2 <= 1'b0; r_special2 <= 1'b0; r_xs2 <= 1'b0;
            r_rm2 <= '0; r_exp2 <= '0; r_sig2 <= '0;
            r_v3 <= 1'b0; r_sign3 <= 1'b0; r_special3 <= 1'b0; r_inc3 <= 1'b0;
            r_rm3 <= '0; r_exp3 <= '0; r_frac3 <= '0;
            r_v4 <= 1'b0; r_o <= '0;
        end else if (ce) begin
            r_v1       <= i_valid;
            r_sign1    <= w_sign;
            r_special1 <= &w_exp;
            r_rm1      <= w_rm;
            r_eEff1    <= (w_exp == '0) ? EW'(1) : w_exp;
            r_lz1      <= w_lz;
            r_sig1     <= w_sig;

            r_v2       <= r_v1;
            r_sign2    <= r_sign1;
            r_special2 <= r_special1;
            r_xs2      <= w_xs2;
            r_rm2      <= r_rm1;
            r_exp2     <= w_exp2;
            r_sig2     <= w_sig2;

            r_v3       <= r_v2;
            r_sign3    <= r_sign2;
            r_special3 <= r_special2;
            r_inc3     <= w_inc;
            r_rm3      <= r_rm2;
            r_exp3     <= r_exp2;
            r_frac3    <= r_sig2[HB-1:FLSB];

            r_v4       <= r_v3;
            if (r_v3) r_o <= w_res;
        end
    end

    assign o       = r_o;
    assign o_valid = r_v4;

`ifdef FP_NORMROUND_FLAGS_EN
    logic r_inexact3, r_inexact4, r_overflow4, r_underflow4;

    // Flags are qualified by valid so they read zero whenever o_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inexact3   <= 1'b0;
            r_inexact4   <= 1'b0;
            r_overflow4  <= 1'b0;
            r_underflow4 <= 1'b0;
        end else if (ce) begin
            r_inexact3   <= w_grs;
            r_inexact4   <= r_v3 & (r_inexact3 | w_ovf);
            r_overflow4  <= r_v3 & w_ovf;
            r_underflow4 <= r_v3 & r_inexact3 & (r_exp3 == '0);
        end
    end

    assign inexact   = r_inexact4;
    assign overflow  = r_overflow4;
    assign underflow = r_underflow4;
`else
    assign inexact   = 1'b0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/fp_normround64.md
Name: fp_normround64

Overview:
- Post-processing stage that consumes the unnormalized extended-format result (FP64X: sign, 11-bit exponent, 106-bit significand) from the double-precision adder/subtracter.
- Normalizes, rounds per IEEE 754 rounding mode and packs into a 64-bit IEEE double.
- Sits directly after the adder (and later the multiplier) in the FPU pipeline; fully pipelined, accepts one operand per enabled clock.

Parameters:
- FMSB, 51, MSB index of stored fraction.
- EMSB, 10, MSB index of exponent.
- FX, 105, MSB index of extended significand.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- ce  in  1  core clock enable; all stages hold when low.
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf, 4 RMM; 5-7 treated as RNE.
- i_valid  in  1  input qualifier.
- i  in  118  FP64X {sign, exp[10:0], sig[105:0]}.
- o  out  64  packed IEEE double.
- o_valid  out  1  output qualifier.
- inexact  out  1  result rounded.
- overflow  out  1  result exceeded max finite.
- underflow  out  1  tiny and inexact.

Behaviour:
- Significand layout: bit 105 carry, bit 104 hidden, 103:52 fraction, 51 guard, 50 round, 49:0 sticky (OR-reduced). Exponent field e weights bit 104.
- Latency: exactly 4 ce-qualified rising edges from i_valid to o_valid. rm travels with its data. One result per enabled clock. No back-pressure.
- ce low: every register, including the valid chain, holds.
- Reset: rst high clears all stage registers asynchronously. o=0, o_valid=0, flags=0. Data in flight is discarded; the first valid result after release appears 4 enabled edges after the next i_valid.
- Stage 1: register inputs. Compute carry (sig[105]). Compute leading-zero count lz of sig[104:0] (0..105). Set e_eff = (e==0) ? 1 : e.
- Stage 2, carry path: shift right 1, exp = e_eff+1, dropped bit ORed into sticky.
- Stage 2, otherwise: shift left s = min(lz, e_eff-1), exp = e_eff - s. If bit 104 is still 0 after the shift, the result is denormal and the exp field is 0.
- Stage 2, zero: sig==0 gives exp 0, frac 0, sign preserved.
- Stage 3: form G, R, S.
  - inc = RNE: G&(R|S|lsb); RTZ: 0; +inf: ~sign&(G|R|S); -inf: sign&(G|R|S); RMM: G.
  - inexact = G|R|S.
- Stage 4: add inc to the 63-bit {exp, frac} concatenation so carries propagate naturally (denormal to min-normal, fraction wrap to exp+1).
  - If the resulting exp is 0x7FF: overflow=1, inexact=1. Result is inf for RNE, RMM, and directed modes toward the result sign. Otherwise it is max finite 0x7FEFFFFFFFFFFFFF with sign.
  - underflow = inexact & pre-round exp field 0.
- Special path: input e==0x7FF bypasses normalization and rounding. o={sign,0x7FF,sig[103:52]}, flags 0. NaN payload is preserved.
- Flags are valid only in the same cycle as o_valid. They are 0 when o_valid is low.

Optional Feature:
- FP_NORMROUND_FLAGS_EN defined: inexact/overflow/underflow are computed and pipelined as above.
- Undefined: flag logic and registers are omitted, and the three flag ports are tied to 0. o and o_valid are unchanged.

Test Plan:
- sign0, e=0x3FF, sig=bit105 only, rm0 -> o=0x4000000000000000 after 4 ce edges, flags 0.
- e=0x3FF, sig=bit100 only -> lz=4, o=0x3FB0000000000000, inexact 0.
- e=0x3FF, bits 104,52,51 set: rm0 -> 0x3FF0000000000002, inexact 1. rm1 -> 0x3FF0000000000001.
- e=0x7FE, bit105 set: rm0 -> 0x7FF0000000000000, overflow 1. rm1 -> 0x7FEFFFFFFFFFFFFF, overflow 1.
- e=1, bit103 only -> o=0x0008000000000000, underflow 0. e=1, bits103,0 set with rm2 -> 0x0008000000000001, underflow 1.
- Three back-to-back valids, ce low 2 cycles mid-stream -> outputs delayed exactly 2 cycles, none lost. Then rst pulse with 3 in flight -> o_valid=0, o=0 immediately, no stale output afterward.
